// File: rtl/mac_driver_if.sv
// mac_driver_if: operand stream and result return between mac_driver and MAC.
// master = driver side (a/b operands out, mac result in); slave = MAC side.
interface mac_driver_if #(
  parameter int DW = 4,
  parameter int OW = 11
);
  logic signed [DW-1:0] a_out;
  logic                 a_valid;
  logic signed [DW-1:0] b_out;
  logic                 b_valid;
  logic signed [OW-1:0] mac_out;
  logic                 mac_valid;

  modport master (
    output a_out,
    output a_valid,
    output b_out,
    output b_valid,
    input  mac_out,
    input  mac_valid
  );

  modport slave (
    input  a_out,
    input  a_valid,
    input  b_out,
    input  b_valid,
    output mac_out,
    output mac_valid
  );
endinterface

// File: rtl/mac_driver.sv
// mac_driver: streams two 8-element signed vectors to the dot-product MAC,
// B optionally lagging A, and checks the returned result against its own sum.
// Ports: clk/reset; host write port (wr_en, wr_sel, wr_addr, wr_data);
// start/skew_b; mac (operand stream + result); busy, expected, result,
// done, match, timeout status.
module mac_driver #(
  parameter int VEC_LEN = 8,
  parameter int DW      = 4,
  parameter int OW      = 11,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [2:0]           wr_addr,
  input  logic signed [DW-1:0] wr_data,
  input  logic                 start,
  input  logic [1:0]           skew_b,
  mac_driver_if.master         mac,
  output logic                 busy,
  output logic signed [OW-1:0] expected,
  output logic signed [OW-1:0] result,
  output logic                 done,
  output logic                 match,
  output logic                 timeout
);

  localparam int PW = 2 * DW;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RES,
    DONE
  } state_t;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic [3:0]           wcnt_q;
  logic [1:0]           skew_q;
  logic signed [DW-1:0] bufa_q [VEC_LEN];
  logic signed [DW-1:0] bufb_q [VEC_LEN];
  logic signed [DW-1:0] a_out_q;
  logic signed [DW-1:0] b_out_q;
  logic                 a_valid_q;
  logic                 b_valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 match_q;
  logic                 timeout_q;
  logic signed [OW-1:0] exp_q;
  logic signed [OW-1:0] res_q;

  logic                 wr_ok;
  logic                 load;
  logic                 last;
  logic [3:0]           k_d;
  logic [3:0]           kb_d;
  logic [3:0]           end_d;
  logic [1:0]           skew_d;
  logic [2:0]           ia;
  logic [2:0]           ib;
  logic                 av_d;
  logic                 bv_d;
  logic signed [DW-1:0] a_d;
  logic signed [DW-1:0] b_d;
  logic signed [DW-1:0] pa_d;
  logic signed [PW-1:0] prod;
  logic signed [OW-1:0] prod_x;
  logic signed [OW-1:0] exp_d;

  // k_d is the SEND cycle index being loaded into the output registers.
  // On the start cycle a same-cycle write is forwarded so the new value
  // is what gets streamed and summed.
  always_comb begin
    wr_ok  = wr_en && (state_q == IDLE);
    load   = start && (state_q == IDLE);
    k_d    = load ? 4'd0 : cnt_q + 4'd1;
    skew_d = load ? skew_b : skew_q;
    kb_d   = k_d - {2'b00, skew_d};
    ia     = k_d[2:0];
    ib     = kb_d[2:0];
    av_d   = k_d < 4'(VEC_LEN);
    bv_d   = (k_d >= {2'b00, skew_d}) && (kb_d < 4'(VEC_LEN));
    end_d  = 4'(VEC_LEN) + {2'b00, skew_q};
    last   = k_d == end_d;
    a_d    = bufa_q[ia];
    pa_d   = bufa_q[ib];
    b_d    = bufb_q[ib];
    if (wr_ok && !wr_sel && wr_addr == ia) a_d = wr_data;
    if (wr_ok && !wr_sel && wr_addr == ib) pa_d = wr_data;
    if (wr_ok && wr_sel && wr_addr == ib) b_d = wr_data;
    prod   = pa_d * b_d;
    prod_x = {{(OW - PW){prod[PW-1]}}, prod};
    exp_d  = (load ? '0 : exp_q) + (bv_d ? prod_x : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      skew_q    <= '0;
      a_out_q   <= '0;
      b_out_q   <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      exp_q     <= '0;
      res_q     <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        bufa_q[i] <= '0;
        bufb_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_en) begin
            if (wr_sel) bufb_q[wr_addr] <= wr_data;
            else        bufa_q[wr_addr] <= wr_data;
          end
          if (start) begin
            state_q   <= SEND;
            skew_q    <= skew_b;
            cnt_q     <= k_d;
            busy_q    <= 1'b1;
            res_q     <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            exp_q     <= exp_d;
            a_valid_q <= av_d;
            a_out_q   <= av_d ? a_d : '0;
            b_valid_q <= bv_d;
            b_out_q   <= bv_d ? b_d : '0;
          end
        end
        SEND: begin
          if (last) begin
            state_q   <= WAIT_RES;
            wcnt_q    <= '0;
            a_valid_q <= 1'b0;
            a_out_q   <= '0;
            b_valid_q <= 1'b0;
            b_out_q   <= '0;
          end else begin
            cnt_q     <= k_d;
            exp_q     <= exp_d;
            a_valid_q <= av_d;
            a_out_q   <= av_d ? a_d : '0;
            b_valid_q <= bv_d;
            b_out_q   <= bv_d ? b_d : '0;
          end
        end
        WAIT_RES: begin
          // A result on the last count cycle still beats the timeout.
          if (mac.mac_valid) begin
            state_q <= DONE;
            res_q   <= mac.mac_out;
            match_q <= mac.mac_out == exp_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (wcnt_q == 4'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
            match_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mac.a_out   = a_out_q;
  assign mac.a_valid = a_valid_q;
  assign mac.b_out   = b_out_q;
  assign mac.b_valid = b_valid_q;
  assign busy        = busy_q;
  assign expected    = exp_q;
  assign result      = res_q;
  assign done        = done_q;
  assign match       = match_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mac_driver.sv
// tb_mac_driver: table-driven bench for mac_driver with a behavioural MAC
// and a scoreboard of expected transaction outcomes.
`timescale 1ns/1ps
module tb_mac_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               wr_en;
  logic               wr_sel;
  logic [2:0]         wr_addr;
  logic signed [3:0]  wr_data;
  logic               start;
  logic [1:0]         skew_b;
  logic               busy;
  logic signed [10:0] expected;
  logic signed [10:0] result;
  logic               done;
  logic               match;
  logic               timeout;

  mac_driver_if #(.DW(4), .OW(11)) m ();

  mac_driver dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .skew_b   (skew_b),
    .mac      (m),
    .busy     (busy),
    .expected (expected),
    .result   (result),
    .done     (done),
    .match    (match),
    .timeout  (timeout)
  );

  typedef struct {
    logic [7:0][3:0]    a;
    logic [7:0][3:0]    b;
    logic [1:0]         skew;
    int                 dly;
    int                 off;
    logic signed [10:0] ee;
    logic signed [10:0] er;
    logic               em;
    logic               et;
  } vec_t;

  typedef struct {
    logic signed [10:0] ee;
    logic signed [10:0] er;
    logic               em;
    logic               et;
    int                 lat;
  } exp_t;

  exp_t sbq[$];
  vec_t tv[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_rise, b_rise, b_fall;
  int a_len = 0;
  int b_len = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int mdl_dot = 0;
  int mdl_dly = -1;
  int mdl_off = 0;
  int ma[8] = '{1, 2, 3, 4, 5, 6, 7, -8};
  int mb[8] = '{7, -1, 2, 3, -4, 0, 1, 1};

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MAC plus stream monitor, sampled mid-cycle.
  initial begin
    int av[16];
    int bv[16];
    int na, nb, wc;
    bit pa, pb;
    na = 0; nb = 0; wc = -1; pa = 0; pb = 0;
    a_rise = 0; b_rise = 0; b_fall = 0;
    m.mac_valid = 1'b0;
    m.mac_out = '0;
    forever begin
      @(negedge clk);
      m.mac_valid = 1'b0;
      if (reset) begin
        na = 0; nb = 0; wc = -1; pa = 0; pb = 0;
      end else begin
        if (m.a_valid && !pa) begin
          na = 0; nb = 0; a_rise = cyc;
        end
        if (m.b_valid && !pb) b_rise = cyc;
        if (m.a_valid) begin
          if (na < 16) av[na] = int'(m.a_out);
          na++; a_len++;
        end
        if (m.b_valid) begin
          if (nb < 16) bv[nb] = int'(m.b_out);
          nb++; b_len++;
        end
        if (!m.b_valid && pb) begin
          b_fall = cyc;
          wc = 0;
          mdl_dot = 0;
          for (int i = 0; i < 8; i++) mdl_dot += av[i] * bv[i];
        end else if (wc >= 0) begin
          wc++;
        end
        if (wc >= 0 && wc == mdl_dly) begin
          m.mac_out = 11'(mdl_dot + mdl_off);
          m.mac_valid = 1'b1;
          wc = -1;
        end
        if (wc > 40) wc = -1;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        pa = m.a_valid;
        pb = m.b_valid;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  function automatic logic [7:0][3:0] fill(input int v);
    logic [7:0][3:0] r;
    for (int i = 0; i < 8; i++) r[i] = 4'(v);
    return r;
  endfunction

  function automatic vec_t mkv(
    input logic [7:0][3:0] a, input logic [7:0][3:0] b,
    input int sk, input int dly, input int off,
    input int ee, input int er, input int em, input int et);
    vec_t v;
    v.a = a; v.b = b; v.skew = 2'(sk);
    v.dly = dly; v.off = off;
    v.ee = 11'(ee); v.er = 11'(er);
    v.em = em[0]; v.et = et[0];
    return v;
  endfunction

  task automatic wr(input logic sel, input int idx, input logic [3:0] val);
    wr_en = 1'b1; wr_sel = sel;
    wr_addr = 3'(idx); wr_data = val;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [1:0] sk, input exp_t e, input bit inj);
    int sc, d0;
    bit ok;
    exp_t x;
    sbq.push_back(e);
    a_len = 0; b_len = 0;
    d0 = done_cnt;
    start = 1'b1; skew_b = sk; sc = cyc;
    tick();
    start = 1'b0; skew_b = 2'd0;
    chk("busy_on", int'(busy), 1);
    if (inj) begin
      tick(); tick();
      start = 1'b1; skew_b = 2'd3;
      wr_en = 1'b1; wr_sel = 1'b0;
      wr_addr = 3'd0; wr_data = -4'sd8;
      tick();
      start = 1'b0; wr_en = 1'b0; skew_b = 2'd0;
    end
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (done) ok = 1;
      else tick();
    end
    chk("done_seen", int'(ok), 1);
    x = sbq.pop_front();
    if (ok) begin
      chk("start_to_a", a_rise - sc, 1);
      chk("a_len", a_len, 8);
      chk("b_len", b_len, 8);
      chk("b_skew", b_rise - a_rise, int'(sk));
      chk("send_len", b_fall - a_rise, 8 + int'(sk));
      chk("done_lat", done_cyc - b_fall, x.lat);
      chk("stream_dot", mdl_dot, int'(x.ee));
      chk("expected", int'(expected), int'(x.ee));
      chk("result", int'(result), int'(x.er));
      chk("match", int'(match), int'(x.em));
      chk("timeout", int'(timeout), int'(x.et));
      chk("busy_done", int'(busy), 0);
      tick();
      chk("done_pulse", int'(done), 0);
      chk("done_count", done_cnt - d0, 1);
      chk("match_hold", int'(match), int'(x.em));
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    mdl_dly = v.dly;
    mdl_off = v.off;
    for (int i = 0; i < 8; i++) wr(1'b0, i, v.a[i]);
    for (int i = 0; i < 8; i++) wr(1'b1, i, v.b[i]);
    e.ee = v.ee; e.er = v.er; e.em = v.em; e.et = v.et;
    e.lat = v.et ? 15 : v.dly + 1;
    go(v.skew, e, 1'b0);
  endtask

  initial begin
    logic [7:0][3:0] mixa, mixb;
    exp_t e;
    int d0;
    for (int i = 0; i < 8; i++) begin
      mixa[i] = 4'(ma[i]);
      mixb[i] = 4'(mb[i]);
    end
    tv[0] = mkv(fill(1), fill(1), 0, 2, 0, 8, 8, 1, 0);
    tv[1] = mkv(fill(-8), fill(7), 0, 2, 0, -448, -448, 1, 0);
    tv[2] = mkv(fill(-8), fill(7), 0, 2, 1, -448, -447, 0, 0);
    tv[3] = mkv(fill(-8), fill(-8), 3, 1, 0, 512, 512, 1, 0);
    tv[4] = mkv(mixa, mixb, 2, 0, 0, 2, 2, 1, 0);
    tv[5] = mkv(fill(1), fill(1), 1, -1, 0, 8, 0, 0, 1);
    tv[6] = mkv(fill(1), fill(1), 0, 14, 0, 8, 8, 1, 0);
    tv[7] = mkv(fill(1), fill(1), 2, 15, 0, 8, 0, 0, 1);

    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0;
    wr_addr = '0; wr_data = '0; start = 1'b0; skew_b = '0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_expected", int'(expected), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_match", int'(match), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_a_valid", int'(m.a_valid), 0);
    chk("rst_b_valid", int'(m.b_valid), 0);

    for (int i = 0; i < 8; i++) run_vec(tv[i]);

    // Asynchronous reset in the middle of the stream.
    mdl_dly = 2; mdl_off = 0;
    for (int i = 0; i < 8; i++) wr(1'b0, i, 4'sd3);
    for (int i = 0; i < 8; i++) wr(1'b1, i, 4'sd2);
    a_len = 0; b_len = 0;
    d0 = done_cnt;
    start = 1'b1; skew_b = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && a_len < 5; i++) tick();
    chk("beat4_reached", a_len, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_a_valid", int'(m.a_valid), 0);
    chk("arst_b_valid", int'(m.b_valid), 0);
    chk("arst_busy", int'(busy), 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    chk("arst_no_done", done_cnt - d0, 0);
    e.ee = 0; e.er = 0; e.em = 1'b1; e.et = 1'b0; e.lat = 3;
    go(2'd0, e, 1'b0);

    // start and wr_en during SEND must be ignored.
    mdl_dly = 3; mdl_off = 0;
    for (int i = 0; i < 8; i++) wr(1'b0, i, 4'sd2);
    for (int i = 0; i < 8; i++) wr(1'b1, i, 4'sd3);
    e.ee = 48; e.er = 48; e.em = 1'b1; e.et = 1'b0; e.lat = 4;
    go(2'd1, e, 1'b1);
    go(2'd0, e, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
